// File: rtl/alu_muldiv_ctrl.sv
// ALU with a multicycle shift-add multiplier and restoring divider feeding HI/LO.
// Define ALU_MULDIV_DIV_EN to build the divider and decode div/divu; otherwise they decode as illegal.
module alu_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MFHI, OP_MFLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
  } op_t;

  state_t           state, state_nxt;
  op_t              op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic             neg_q;
  logic [WIDTH-1:0] alu_res;
  logic             accept, is_long, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_MULDIV_DIV_EN
  logic             is_div, neg_r;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
`endif

  // NOTE: combinational blocks assign every output a default first so no path can infer a latch.
  always_comb begin
    op = OP_ILL;
    case (aluop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (opcode)
          6'b001000: op = OP_ADD;
          6'b001100: op = OP_AND;
          6'b001101: op = OP_OR;
          6'b001010: op = OP_SLT;
          default:   op = OP_ILL;
        endcase
      end
      default: begin
        case (funct)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b101010: op = OP_SLT;
          6'b010000: op = OP_MFHI;
          6'b010010: op = OP_MFLO;
          6'b011000: op = OP_MULT;
          6'b011001: op = OP_MULTU;
`ifdef ALU_MULDIV_DIV_EN
          6'b011010: op = OP_DIV;
          6'b011011: op = OP_DIVU;
`endif
          default:   op = OP_ILL;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  assign accept    = start && (state == S_IDLE);
  assign is_long   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign busy      = (state != S_IDLE);
  assign zero      = (result == '0);

  // Multiplier: acc_lo holds the remaining multiplier bits, product shifts in from the top.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
`ifdef ALU_MULDIV_DIV_EN
  // Divider: partial remainder in acc_hi, dividend bits shift out of acc_lo as quotient bits shift in.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb};
  assign div_sub   = div_shift[WIDTH-1:0] - opb;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_long) state_nxt = S_RUN;
      S_RUN:   if (cnt == CNT_W'(WIDTH-1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opb     <= '0;
      neg_q   <= 1'b0;
      result  <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      is_div  <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_ILL) begin
              done    <= 1'b1;
              illegal <= 1'b1;
            end else if (is_long) begin
              cnt    <= '0;
              acc_hi <= '0;
              acc_lo <= a_mag;
              opb    <= b_mag;
              neg_q  <= a_neg ^ b_neg;
`ifdef ALU_MULDIV_DIV_EN
              is_div <= (op == OP_DIV) || (op == OP_DIVU);
              neg_r  <= a_neg;
`endif
            end else begin
              result <= alu_res;
              done   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + CNT_W'(1);
`ifdef ALU_MULDIV_DIV_EN
          if (is_div) begin
            acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else
`endif
          begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          done <= 1'b1;
`ifdef ALU_MULDIV_DIV_EN
          if (is_div) begin
            // Zero divisor: remainder magnitude is |a|, so sign-correcting it restores a exactly.
            hi <= neg_r ? -acc_hi : acc_hi;
            if (opb == '0) lo <= '1;
            else           lo <= neg_q ? -acc_lo : acc_lo;
          end else
`endif
          begin
            {hi, lo} <= neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Scoreboard bench for alu_muldiv_ctrl (WIDTH=32): driver predicts with plain arithmetic, monitor checks on done.
module tb_alu_muldiv_ctrl;
  localparam int W = 32;
`ifdef ALU_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    aluop = '0;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  result, hi, lo;
  logic          zero, busy, done, illegal;

  alu_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .opcode(opcode),
    .funct(funct), .a(a), .b(b), .result(result), .zero(zero), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         illegal;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] m_result = '0, m_hi = '0, m_lo = '0;
  logic [5:0]   fn_list[12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b010000,
                                6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b111111};
  logic [5:0]   opc_list[5] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decode the instruction table and compute the architectural effect directly.
  task automatic predict(input logic [1:0] op2, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [W-1:0] av, input logic [W-1:0] bv, output exp_t e);
    string  k;
    longint sa, sb_, q, r;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb_ = longint'($signed(bv));
    k = "ill";
    case (op2)
      2'b00: k = "add";
      2'b01: k = "sub";
      2'b10: case (opc)
        6'b001000: k = "add";
        6'b001100: k = "and";
        6'b001101: k = "or";
        6'b001010: k = "slt";
        default:   k = "ill";
      endcase
      default: case (fn)
        6'b100000: k = "add";
        6'b100010: k = "sub";
        6'b100100: k = "and";
        6'b100101: k = "or";
        6'b101010: k = "slt";
        6'b010000: k = "mfhi";
        6'b010010: k = "mflo";
        6'b011000: k = "mult";
        6'b011001: k = "multu";
        6'b011010: k = DIV_EN ? "div" : "ill";
        6'b011011: k = DIV_EN ? "divu" : "ill";
        default:   k = "ill";
      endcase
    endcase
    e.illegal = 1'b0;
    e.due = cyc + 1;
    case (k)
      "add":  m_result = av + bv;
      "sub":  m_result = av - bv;
      "and":  m_result = av & bv;
      "or":   m_result = av | bv;
      "slt":  m_result = (sa < sb_) ? 1 : 0;
      "mfhi": m_result = m_hi;
      "mflo": m_result = m_lo;
      "mult": begin p = 64'(sa * sb_); {m_hi, m_lo} = p; e.due = cyc + W + 2; end
      "multu": begin p = {32'b0, av} * {32'b0, bv}; {m_hi, m_lo} = p; e.due = cyc + W + 2; end
      "div", "divu": begin
        e.due = cyc + W + 2;
        if (bv == 0) begin
          m_lo = '1;
          m_hi = av;
        end else if (k == "div") begin
          q = sa / sb_;
          r = sa % sb_;
          m_lo = W'(q);
          m_hi = W'(r);
        end else begin
          m_lo = av / bv;
          m_hi = av % bv;
        end
      end
      default: e.illegal = 1'b1;
    endcase
    e.result = m_result;
    e.hi = m_hi;
    e.lo = m_lo;
  endtask

  task automatic issue(input logic [1:0] op2, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    predict(op2, opc, fn, av, bv, e);
    sb.push_back(e);
    aluop = op2; opcode = opc; funct = fn; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int exp_busy);
    int n = 0;
    int busy_cnt = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      n++;
    end
    check("done_seen", 64'(sb.size()), 0);
    check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op2, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [W-1:0] av, input logic [W-1:0] bv);
    int lng;
    issue(op2, opc, fn, av, bv);
    lng = (sb[sb.size()-1].due - cyc > 1) ? W + 1 : 0;
    wait_done(lng);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no outstanding request (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.result));
        check("zero", 64'(zero), 64'(e.result == 0));
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("illegal", 64'(illegal), 64'(e.illegal));
        check("done_cycle", 64'(cyc), 64'(e.due));
        check("busy_at_done", 64'(busy), 0);
      end
    end
  end

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_illegal"}, 64'(illegal), 0);
    check({tag, "_result"}, 64'(result), 0);
    check({tag, "_zero"}, 64'(zero), 1);
    check({tag, "_hi"}, 64'(hi), 0);
    check({tag, "_lo"}, 64'(lo), 0);
  endtask

  initial begin
    logic [1:0] op2;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases from the block's verification list.
    run_op(2'b11, 6'd0, 6'b100000, 32'd5, 32'd7);
    run_op(2'b11, 6'd0, 6'b011000, 32'hFFFF_FFFD, 32'd7);
    run_op(2'b11, 6'd0, 6'b010010, 32'd0, 32'd0);
    run_op(2'b11, 6'd0, 6'b011010, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 6'd0, 6'b011010, 32'd9, 32'd0);
    run_op(2'b11, 6'd0, 6'b010000, 32'd0, 32'd0);
    run_op(2'b10, 6'b000000, 6'd0, 32'd3, 32'd4);
    run_op(2'b11, 6'd0, 6'b011011, 32'd100, 32'd7);
    run_op(2'b11, 6'd0, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 6'b001010, 6'd0, 32'hFFFF_FFFF, 32'd1);
    run_op(2'b01, 6'd0, 6'd0, 32'd0, 32'd1);
    run_op(2'b00, 6'd0, 6'd0, 32'hFFFF_FFFF, 32'd1);

    // Back-to-back single-cycle ops: second start lands in the done cycle of the first.
    issue(2'b00, 6'd0, 6'd0, 32'd10, 32'd20);
    issue(2'b10, 6'b001101, 6'd0, 32'hF0, 32'h0F);
    wait_done(0);

    // Start during RUN is ignored: no extra done, model untouched.
    issue(2'b11, 6'd0, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #1 aluop = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(W + 1 - 6);
    repeat (3) @(posedge clk);
    #1 run_op(2'b11, 6'd0, 6'b010000, 32'd0, 32'd0);

    // Reset in the middle of a multiply aborts it without touching HI/LO.
    issue(2'b11, 6'd0, 6'b011000, 32'd12345, 32'd678);
    repeat (9) @(posedge clk);
    #1 check("busy_before_abort", 64'(busy), 1);
    rst_n = 1'b0;
    #1 check_reset_state("abort");
    sb.delete();
    m_result = '0; m_hi = '0; m_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    repeat (W + 4) @(posedge clk);
    #1 run_op(2'b11, 6'd0, 6'b010010, 32'd0, 32'd0);

    // Randomized mix over all decode paths.
    for (int i = 0; i < 80; i++) begin
      op2 = 2'($urandom_range(0, 3));
      run_op(op2, opc_list[$urandom_range(0, 4)], fn_list[$urandom_range(0, 11)], rand_opnd(), rand_opnd());
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_muldiv_ctrl.md
ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, datapath width in bits (legal 8..64, even).
REQ-002 SHALL provide parameter: CNT_W, $clog2(WIDTH)+1, iteration counter width.
REQ-003 SHALL have one clock and an asynchronous active-low reset, listed first as: clk  input  1  rising-edge clock; rst_n  input  1  async active-low reset.
REQ-004 SHALL have ports: start  input  1  request, sampled only when busy=0.
REQ-005 SHALL have ports: aluop  input  2  00 add, 01 sub, 10 immediate (by opcode), 11 R-type (by funct).
REQ-006 SHALL have ports: opcode  input  6; funct  input  6.
REQ-007 SHALL have ports: a  input  WIDTH; b  input  WIDTH  operands.
REQ-008 SHALL have ports: result  output  WIDTH; zero  output  1 (result==0).
REQ-009 SHALL have ports: hi  output  WIDTH; lo  output  WIDTH  architectural HI/LO.
REQ-010 SHALL have ports: busy  output  1; done  output  1  one-cycle completion pulse; illegal  output  1  valid with done.

Function
REQ-011 Decode SHALL be: aluop 00 add; 01 sub; 10 opcode 001000 add, 001100 and, 001101 or, 001010 slt; 11 funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 010000 mfhi, 010010 mflo, 011000 mult, 011001 multu, 011010 div, 011011 divu.
REQ-012 Any other combination SHALL be illegal: done+illegal=1 next cycle, result, hi, lo unchanged.
REQ-013 Add/sub SHALL wrap modulo 2^WIDTH; slt SHALL compare signed, result 1 or 0 zero-extended.
REQ-014 Single-cycle ops (add, sub, and, or, slt, mfhi, mflo): result, zero registered on the edge after the start cycle; done=1 that next cycle; busy stays 0.
REQ-015 State machine SHALL be IDLE, RUN, FIX; mult/div: IDLE->RUN on accepted start (operand magnitudes latched, count=0), RUN for WIDTH cycles (shift-add multiply / restoring divide, one bit per cycle), RUN->FIX when count=WIDTH-1, FIX->IDLE.
REQ-016 busy SHALL be 1 in RUN and FIX; done SHALL pulse in the cycle after FIX, i.e. WIDTH+2 cycles after the start cycle.
REQ-017 hi/lo SHALL update on the FIX->IDLE edge only: mult/multu hi:lo = 2*WIDTH-bit product; div/divu lo=quotient, hi=remainder.
REQ-018 Signed variants SHALL sign-correct in FIX: product negated if signs differ; quotient truncates toward zero; remainder takes the dividend's sign.
REQ-019 Divide by zero SHALL give lo=all ones, hi=a, illegal=0, same latency.
REQ-020 start while busy=1 SHALL be ignored with no state change; mfhi/mflo issued during RUN are therefore not accepted.
REQ-021 result SHALL hold its last value during mult/div; hi/lo never change except per REQ-017 or reset.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, counters 0, result=0, zero=1, hi=0, lo=0, busy=0, done=0, illegal=0, aborting any operation without HI/LO update.
REQ-023 First start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-024 Macro ALU_MULDIV_DIV_EN defined: divider datapath and div/divu decode per REQ-015..019.
REQ-025 Macro ALU_MULDIV_DIV_EN undefined: no divider logic; div/divu decode as illegal per REQ-012; mult/multu unaffected.

Verification (WIDTH=32)
REQ-026 aluop=11, funct=100000, a=5, b=7, start -> next cycle done=1, result=12, zero=0, busy=0.
REQ-027 funct=011000, a=0xFFFFFFFD, b=7 -> busy 33 cycles, done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; then funct=010010 -> result=0xFFFFFFEB.
REQ-028 funct=011010, a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=9, b=0 -> lo=0xFFFFFFFF, hi=9.
REQ-029 start add during mult RUN -> ignored, no extra done; rst_n low at cycle 10 of mult -> busy=0, hi=lo=0 immediately, no done.
REQ-030 aluop=10, opcode=000000 -> done=1, illegal=1, result unchanged; with ALU_MULDIV_DIV_EN undefined, funct=011010 -> done=1, illegal=1 next cycle.
